// File: rtl/mult_add_param.sv
// Sequential shift-add multiply-accumulate: product = multiplicand*multiplier + addend,
// one multiplier bit per clock, fixed latency, strt/idle handshake.
module mult_add_param #(
    parameter int unsigned BITSIZE   = 8,
    parameter int unsigned INDEXSIZE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   strt,
    input  logic [BITSIZE-1:0]     multiplicand,
    input  logic [BITSIZE-1:0]     multiplier,
    input  logic [BITSIZE-1:0]     addend,
    output logic [2*BITSIZE-1:0]   product,
    output logic                   done,
    output logic                   idle
);

    localparam int unsigned W2 = 2 * BITSIZE;
    localparam logic [INDEXSIZE-1:0] LAST_IDX = INDEXSIZE'(BITSIZE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CALC     = 2'b11,
        POSTCALC = 2'b10
    } state_t;

    state_t               state;
    logic [W2-1:0]        acc;
    logic [BITSIZE-1:0]   mcand;
    logic [BITSIZE-1:0]   mplier;
    logic [INDEXSIZE-1:0] cnt;
    logic [W2-1:0]        shifted;

    // Partial product for the current multiplier bit; the 2N-bit sum never carries out.
    assign shifted = W2'(mcand) << cnt;
    assign idle    = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            product <= '0;
            done    <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (strt) begin
                        acc    <= W2'(addend);
                        mcand  <= multiplicand;
                        mplier <= multiplier;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[cnt]) begin
                        acc <= acc + shifted;
                    end
                    cnt <= cnt + INDEXSIZE'(1);
                    if (cnt == LAST_IDX) begin
                        state <= POSTCALC;
                    end
                end
                POSTCALC: begin
                    product <= acc;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_add_param.sv
// Bench for mult_add_param at BITSIZE=8 and BITSIZE=16: per-cycle comparison against a
// transaction-level model plus directed vectors with hand-computed results.
module tb_mult_add_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        strt8;
    logic [7:0]  a8, b8, c8;
    logic [15:0] p8;
    logic        done8, idle8;

    logic        strt16;
    logic [15:0] a16, b16, c16;
    logic [31:0] p16;
    logic        done16, idle16;

    mult_add_param #(.BITSIZE(8), .INDEXSIZE(3)) dut8 (
        .clk(clk), .rst(rst), .strt(strt8),
        .multiplicand(a8), .multiplier(b8), .addend(c8),
        .product(p8), .done(done8), .idle(idle8)
    );

    mult_add_param #(.BITSIZE(16), .INDEXSIZE(4)) dut16 (
        .clk(clk), .rst(rst), .strt(strt16),
        .multiplicand(a16), .multiplier(b16), .addend(c16),
        .product(p16), .done(done16), .idle(idle16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted op completes N+1 edges after acceptance with A*B+C.
    longint unsigned m8_prod, m8_pend, m16_prod, m16_pend;
    int              m8_rem, m16_rem;
    bit              m8_done, m16_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8_prod = 0;  m8_pend = 0;  m8_rem = 0;  m8_done = 1'b0;
            m16_prod = 0; m16_pend = 0; m16_rem = 0; m16_done = 1'b0;
        end else begin
            m8_done  = 1'b0;
            m16_done = 1'b0;
            if (m8_rem > 0) begin
                m8_rem--;
                if (m8_rem == 0) begin
                    m8_prod = m8_pend;
                    m8_done = 1'b1;
                end
            end else if (strt8) begin
                m8_pend = longint'(a8) * longint'(b8) + longint'(c8);
                m8_rem  = 9;
            end
            if (m16_rem > 0) begin
                m16_rem--;
                if (m16_rem == 0) begin
                    m16_prod = m16_pend;
                    m16_done = 1'b1;
                end
            end else if (strt16) begin
                m16_pend = longint'(a16) * longint'(b16) + longint'(c16);
                m16_rem  = 17;
            end
        end
    end

    // Single compare process: every cycle outside reset, both instances against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("p8",     longint'(p8),     m8_prod);
            check("done8",  longint'(done8),  longint'(m8_done));
            check("idle8",  longint'(idle8),  longint'(m8_rem == 0));
            check("p16",    longint'(p16),    m16_prod);
            check("done16", longint'(done16), longint'(m16_done));
            check("idle16", longint'(idle16), longint'(m16_rem == 0));
            if (m8_done)  check("carry8",  m8_prod >> 16, 0);
            if (m16_done) check("carry16", m16_prod >> 32, 0);
        end
    end

    // Start an 8-bit op at the current negedge and wait for done; optionally
    // pulse strt mid-CALC. Operands are scrambled after the start edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input longint unsigned exp, input string nm, input bit pulse);
        int cyc;
        a8 = a; b8 = b; c8 = c; strt8 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            strt8 = (pulse && cyc == 3) ? 1'b1 : 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
        end while (!done8 && cyc < 40);
        strt8 = 1'b0;
        check({nm, "_lat"},  longint'(cyc),   10);
        check({nm, "_p"},    longint'(p8),    exp);
        check({nm, "_idle"}, longint'(idle8), 1);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input string nm);
        int cyc;
        longint unsigned exp;
        exp = longint'(a) * longint'(b) + longint'(c);
        a16 = a; b16 = b; c16 = c; strt16 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            strt16 = 1'b0;
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 16'($urandom);
        end while (!done16 && cyc < 60);
        check({nm, "_lat"}, longint'(cyc), 18);
        check({nm, "_p"},   longint'(p16), exp);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cyc;
        logic [7:0]  ra, rb, rc;
        logic [15:0] sa, sb, sc;

        rst = 1'b1; strt8 = 1'b0; strt16 = 1'b0;
        a8 = '0; b8 = '0; c8 = '0; a16 = '0; b16 = '0; c16 = '0;
        repeat (2) @(negedge clk);
        check("rst_p8",    longint'(p8),     0);
        check("rst_done8", longint'(done8),  0);
        check("rst_idle8", longint'(idle8),  1);
        check("rst_p16",   longint'(p16),    0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        run8(8'd13,  8'd19,  8'd7,   254,      "t1",  1'b0);
        run8(8'd255, 8'd255, 8'd255, 'hFF00,   "t2",  1'b0);
        run8(8'd0,   8'd200, 8'd45,  45,       "t3a", 1'b0);
        run8(8'd200, 8'd0,   8'd0,   0,        "t3b", 1'b0);
        run8(8'd100, 8'd50,  8'd9,   5009,     "t4b", 1'b1);

        // strt held high: a new op is accepted in each done cycle.
        a8 = 8'd3; b8 = 8'd5; c8 = 8'd1; strt8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done8 && cyc < 40);
            check("t4_interval", longint'(cyc), 10);
            check("t4_p",        longint'(p8),  16);
        end
        strt8 = 1'b0;
        @(negedge clk);

        // Reset in the 4th CALC cycle aborts at once and clears product.
        a8 = 8'd17; b8 = 8'd23; c8 = 8'd4; strt8 = 1'b1;
        @(negedge clk);
        strt8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_idle", longint'(idle8), 1);
        check("t5_p",    longint'(p8),    0);
        check("t5_done", longint'(done8), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run8(8'd7, 8'd6, 8'd5, 47, "t5_next", 1'b0);

        // 16-bit directed corners.
        run16(16'hFFFF, 16'hFFFF, 16'hFFFF, "w16_max");
        run16(16'd1234, 16'd0,    16'd999,  "w16_zero");

        // Random vectors; odd iterations are divider-style triples with C < A.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(1, 255));
            rb = 8'($urandom);
            rc = (i % 2 == 1) ? 8'($urandom % ra) : 8'($urandom);
            run8(ra, rb, rc, longint'(ra) * longint'(rb) + longint'(rc), "r8", 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            sa = 16'($urandom_range(1, 65535));
            sb = 16'($urandom);
            sc = (i % 2 == 1) ? 16'($urandom % sa) : 16'($urandom);
            run16(sa, sb, sc, "r16");
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
